// File: rtl/fetch_decode_stage_pkg.sv
// Shared definitions for the fetch/decode front end: opcode encodings,
// register names and instruction field bit positions.
package fetch_decode_stage_pkg;

  // Opcode encodings (instruction[27:24]); the all-zero word is NOP
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_BLE = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_LED = 4'h6;

  // Register name constants used in the 8-bit operand fields
  localparam logic [7:0] REG_R0  = 8'h00;
  localparam logic [7:0] REG_R1  = 8'h01;
  localparam logic [7:0] REG_R2  = 8'h02;
  localparam logic [7:0] REG_R3  = 8'h03;
  localparam logic [7:0] REG_LED = 8'hFF;

  // Field bit positions inside the 28-bit instruction word
  localparam int OPC_MSB  = 27;
  localparam int OPC_LSB  = 24;
  localparam int DEST_MSB = 23;
  localparam int DEST_LSB = 16;
  localparam int SRC1_MSB = 15;
  localparam int SRC1_LSB = 8;
  localparam int SRC0_MSB = 7;
  localparam int SRC0_LSB = 0;
  localparam int LIT_MSB  = 15;
  localparam int LIT_LSB  = 0;

  // Full NOP instruction word
  localparam logic [27:0] NOP_WORD = 28'h0000000;

endpackage

// File: rtl/fetch_decode_stage_program_counter.sv
// Program counter register: reset, load-target, hold and increment.
// Priority is reset > load > hold > increment; increment wraps naturally.
module program_counter #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iLoad,
  input  logic [ADDR_WIDTH-1:0] iTarget,
  input  logic                  iHold,
  input  logic                  iIncrement,
  output logic [ADDR_WIDTH-1:0] oPC
);

  logic [ADDR_WIDTH-1:0] r_pc;

  // PC update: redirect beats hold, hold beats sequential increment
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pc <= RESET_PC;
    end else if (iLoad) begin
      r_pc <= iTarget;
    end else if (!iHold && iIncrement) begin
      r_pc <= r_pc + ADDR_WIDTH'(1);
    end
  end

  assign oPC = r_pc;

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode front stage: owns the PC, addresses the instruction ROM,
// registers the returned word and splits it into operand fields.
// Optional feature macro: FETCH_EARLY_JMP_EN (resolve JMP inside fetch).
module fetch_decode_stage #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    INSTR_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  output logic [ADDR_WIDTH-1:0]  oAddress,
  input  logic [INSTR_WIDTH-1:0] iInstruction,
  input  logic                   iStall,
  input  logic                   iBranchTaken,
  input  logic [7:0]             iBranchTarget,
  output logic                   oValid,
  output logic [ADDR_WIDTH-1:0]  oPC,
  output logic [3:0]             oOpcode,
  output logic [7:0]             oDest,
  output logic [7:0]             oSrc1,
  output logic [7:0]             oSrc0,
  output logic [15:0]            oLiteral
);

  import fetch_decode_stage_pkg::*;

  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_pc_issued;
  logic                   r_valid;

  logic [ADDR_WIDTH-1:0]  w_pc;
  logic                   w_early_jmp;
  logic                   w_load;
  logic [ADDR_WIDTH-1:0]  w_target;

  // A JMP seen on the ROM bus is only consumed locally when nothing
  // higher priority (redirect or stall) owns this edge.
`ifdef FETCH_EARLY_JMP_EN
  assign w_early_jmp = !iBranchTaken && !iStall &&
                       (iInstruction[OPC_MSB:OPC_LSB] == OP_JMP);
`else
  assign w_early_jmp = 1'b0;
`endif

  assign w_load   = iBranchTaken || w_early_jmp;
  assign w_target = iBranchTaken
                  ? {{(ADDR_WIDTH-8){1'b0}}, iBranchTarget}
                  : {{(ADDR_WIDTH-8){1'b0}}, iInstruction[DEST_MSB:DEST_LSB]};

  program_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_program_counter (
    .Clock      (Clock),
    .Reset      (Reset),
    .iLoad      (w_load),
    .iTarget    (w_target),
    .iHold      (iStall),
    .iIncrement (1'b1),
    .oPC        (w_pc)
  );

  // Instruction register: a redirect only drops valid so the stale fields
  // stay stable; a locally consumed JMP is replaced by a NOP bubble.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_instr     <= '0;
      r_pc_issued <= '0;
      r_valid     <= 1'b0;
    end else if (iBranchTaken) begin
      r_valid <= 1'b0;
    end else if (!iStall) begin
      if (w_early_jmp) begin
        r_instr <= INSTR_WIDTH'(NOP_WORD);
        r_valid <= 1'b0;
      end else begin
        r_instr     <= iInstruction;
        r_pc_issued <= w_pc;
        r_valid     <= 1'b1;
      end
    end
  end

  assign oAddress = w_pc;
  assign oValid   = r_valid;
  assign oPC      = r_pc_issued;
  assign oOpcode  = r_instr[OPC_MSB:OPC_LSB];
  assign oDest    = r_instr[DEST_MSB:DEST_LSB];
  assign oSrc1    = r_instr[SRC1_MSB:SRC1_LSB];
  assign oSrc0    = r_instr[SRC0_MSB:SRC0_LSB];
  assign oLiteral = r_instr[LIT_MSB:LIT_LSB];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Self-checking bench for fetch_decode_stage: directed scenarios followed
// by randomized stall/redirect/reset traffic against a behavioural model.
module tb_fetch_decode_stage;

  import fetch_decode_stage_pkg::*;

`ifdef FETCH_EARLY_JMP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset, iStall, iBranchTaken;
  logic [7:0]  iBranchTarget;
  logic [15:0] oAddress, oPC, oLiteral;
  logic [27:0] iInstruction;
  logic        oValid;
  logic [3:0]  oOpcode;
  logic [7:0]  oDest, oSrc1, oSrc0;

  logic        Reset2;
  logic [15:0] oAddress2, oPC2, oLiteral2;
  logic [27:0] iInstruction2;
  logic        oValid2;
  logic [3:0]  oOpcode2;
  logic [7:0]  oDest2, oSrc12, oSrc02;

  logic [27:0] rom [256];

  assign iInstruction  = rom[oAddress[7:0]];
  assign iInstruction2 = rom[oAddress2[7:0]];

  fetch_decode_stage dut (
    .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
    .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
    .oValid(oValid), .oPC(oPC), .oOpcode(oOpcode), .oDest(oDest),
    .oSrc1(oSrc1), .oSrc0(oSrc0), .oLiteral(oLiteral)
  );

  fetch_decode_stage #(.RESET_PC(16'hFFFF)) dut_wrap (
    .Clock(Clock), .Reset(Reset2), .oAddress(oAddress2), .iInstruction(iInstruction2),
    .iStall(1'b0), .iBranchTaken(1'b0), .iBranchTarget(8'h00),
    .oValid(oValid2), .oPC(oPC2), .oOpcode(oOpcode2), .oDest(oDest2),
    .oSrc1(oSrc12), .oSrc0(oSrc02), .oLiteral(oLiteral2)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural model state: PC, issued word, its address, valid flag
  logic [15:0] m_pc, m_opc;
  logic [27:0] m_ir;
  logic        m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the stage's rules for one rising edge to the model
  task automatic model_edge();
    logic [27:0] w;
    w = rom[m_pc[7:0]];
    if (Reset) begin
      m_pc = 16'h0000; m_opc = 16'h0000; m_ir = 28'h0; m_valid = 1'b0;
    end else if (iBranchTaken) begin
      m_pc = {8'h00, iBranchTarget}; m_valid = 1'b0;
    end else if (!iStall) begin
      if (EARLY && w[27:24] == OP_JMP) begin
        m_pc = {8'h00, w[23:16]}; m_ir = 28'h0; m_valid = 1'b0;
      end else begin
        m_ir = w; m_opc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic check_model();
    chk("addr", {16'h0, oAddress}, {16'h0, m_pc});
    chk("valid", {31'h0, oValid}, {31'h0, m_valid});
    if (m_valid) begin
      chk("opc_pc", {16'h0, oPC}, {16'h0, m_opc});
      chk("opcode", {28'h0, oOpcode}, {28'h0, m_ir[27:24]});
      chk("dest", {24'h0, oDest}, {24'h0, m_ir[23:16]});
      chk("src1", {24'h0, oSrc1}, {24'h0, m_ir[15:8]});
      chk("src0", {24'h0, oSrc0}, {24'h0, m_ir[7:0]});
      chk("literal", {16'h0, oLiteral}, {16'h0, m_ir[15:0]});
    end
  endtask

  task automatic step();
    @(posedge Clock);
    model_edge();
    #1;
    cyc++;
    $display("cyc=%0d rst=%b stall=%b br=%b addr=%h valid=%b pc=%h op=%h",
             cyc, Reset, iStall, iBranchTaken, oAddress, oValid, oPC, oOpcode);
    check_model();
  endtask

  initial begin
    logic [27:0] w;
    logic [15:0] snap_pc;
    logic [3:0]  snap_op;

    for (int i = 0; i < 256; i++) begin
      w = 28'($urandom);
      if (w[27:24] == OP_JMP) w[27:24] = OP_ADD;
      rom[i] = w;
    end
    rom[14] = {OP_JMP, 8'd2, 16'h1234};

    m_pc = 16'h0; m_opc = 16'h0; m_ir = 28'h0; m_valid = 1'b0;
    Reset = 1'b1; Reset2 = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 8'h00;

    // Reset held for three cycles
    repeat (3) step();
    chk("rst_addr", {16'h0, oAddress}, 32'h0);
    chk("rst_valid", {31'h0, oValid}, 32'h0);
    chk("rst_pc", {16'h0, oPC}, 32'h0);
    chk("rst_opcode", {28'h0, oOpcode}, 32'h0);
    chk("rst_literal", {16'h0, oLiteral}, 32'h0);

    // Release: sequential fetch, oPC lags oAddress by one
    Reset = 1'b0;
    step();
    chk("rel_addr1", {16'h0, oAddress}, 32'd1);
    chk("rel_valid", {31'h0, oValid}, 32'd1);
    chk("rel_pc0", {16'h0, oPC}, 32'd0);
    repeat (4) step();
    chk("pre_stall_addr", {16'h0, oAddress}, 32'd5);

    // Stall for four cycles at address 5
    snap_pc = 16'd4; snap_op = rom[4][27:24];
    iStall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_addr", {16'h0, oAddress}, 32'd5);
      chk("stall_pc", {16'h0, oPC}, {16'h0, snap_pc});
      chk("stall_op", {28'h0, oOpcode}, {28'h0, snap_op});
    end
    iStall = 1'b0;
    step();
    chk("resume_addr", {16'h0, oAddress}, 32'd6);
    chk("resume_pc", {16'h0, oPC}, 32'd5);
    repeat (4) step();
    chk("pre_br_addr", {16'h0, oAddress}, 32'd10);

    // Taken branch to 8: one bubble
    iBranchTaken = 1'b1; iBranchTarget = 8'd8;
    step();
    iBranchTaken = 1'b0;
    chk("br_addr", {16'h0, oAddress}, 32'd8);
    chk("br_bubble", {31'h0, oValid}, 32'd0);
    step();
    chk("br_valid", {31'h0, oValid}, 32'd1);
    chk("br_pc", {16'h0, oPC}, 32'd8);

    // Branch together with stall: redirect wins
    iStall = 1'b1; iBranchTaken = 1'b1; iBranchTarget = 8'd12;
    step();
    iStall = 1'b0; iBranchTaken = 1'b0;
    chk("brstall_addr", {16'h0, oAddress}, 32'd12);
    chk("brstall_valid", {31'h0, oValid}, 32'd0);
    repeat (2) step();
    chk("pre_jmp_addr", {16'h0, oAddress}, 32'd14);
    step();
`ifdef FETCH_EARLY_JMP_EN
    chk("ejmp_addr", {16'h0, oAddress}, 32'd2);
    chk("ejmp_valid", {31'h0, oValid}, 32'd0);
    step();
    chk("ejmp_pc", {16'h0, oPC}, 32'd2);
`else
    chk("jmp_addr", {16'h0, oAddress}, 32'd15);
    chk("jmp_opcode", {28'h0, oOpcode}, {28'h0, OP_JMP});
    chk("jmp_dest", {24'h0, oDest}, 32'd2);
    iBranchTaken = 1'b1; iBranchTarget = 8'd2;
    step();
    iBranchTaken = 1'b0;
    chk("jmp_br_addr", {16'h0, oAddress}, 32'd2);
    step();
    chk("jmp_br_pc", {16'h0, oPC}, 32'd2);
`endif

    // Randomized stall / redirect / reset traffic
    for (int i = 0; i < 400; i++) begin
      Reset         = ($urandom_range(0, 49) == 0);
      iStall        = ($urandom_range(0, 3) == 0);
      iBranchTaken  = ($urandom_range(0, 6) == 0);
      iBranchTarget = 8'($urandom);
      step();
    end
    Reset = 1'b0; iStall = 1'b0; iBranchTaken = 1'b0;

    // PC wrap from 16'hFFFF on the second instance
    chk("wrap_rst_addr", {16'h0, oAddress2}, 32'hFFFF);
    chk("wrap_rst_valid", {31'h0, oValid2}, 32'd0);
    Reset2 = 1'b0;
    step();
    chk("wrap_addr", {16'h0, oAddress2}, 32'd0);
    chk("wrap_valid", {31'h0, oValid2}, 32'd1);
    chk("wrap_pc", {16'h0, oPC2}, 32'hFFFF);
    chk("wrap_opcode", {28'h0, oOpcode2}, {28'h0, rom[255][27:24]});
    step();
    chk("wrap_next_addr", {16'h0, oAddress2}, 32'd1);
    chk("wrap_next_pc", {16'h0, oPC2}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
